fetch_controller: RTL and testbench

//  Sequences the instruction memory: holds the PC, drives imem_addr and captures

---
 rtl/fetch_controller.sv | 136 +++++++++++++
 tb/tb_fetch_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: walks the PC through instruction memory and
// buffers {pc, instr} pairs in a small in-order prefetch FIFO for decode.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | out of reset, no fetching until start
// ST_FETCH | issuing one fetch per cycle whenever the FIFO has room
// ST_HALT  | fetching stopped, buffered entries still drain to decode
module fetch_controller #(
   parameter int                ADDR_W   = 16,
   parameter int                INSTR_W  = 16,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               halt_req,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic               halted
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam int               CNT_W    = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  pc_nxt;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_nxt;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
   logic [INSTR_W-1:0] fifo_instr [DEPTH];
   logic               push;
   logic               pop;

   assign imem_addr = pc;
   assign out_valid = (count != '0);
   assign out_pc    = fifo_pc[rd_ptr];
   assign out_instr = fifo_instr[rd_ptr];
   assign halted    = (state == ST_HALT);

   assign pop  = out_valid & out_ready;
   // a full FIFO can still accept a push when the head leaves in the same cycle
   assign push = (state == ST_FETCH) & ~halt_req & ~redirect_valid &
                 ((count < FULL_CNT) | pop);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start)    state_nxt = ST_FETCH;
         ST_FETCH: if (halt_req) state_nxt = ST_HALT;
         ST_HALT:  if (start)    state_nxt = ST_FETCH;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      pc_nxt    = pc;
      count_nxt = count;
      if (redirect_valid) begin
         // masking keeps the target halfword aligned
         pc_nxt    = redirect_pc & ~ADDR_W'(1);
         count_nxt = '0;
      end else begin
         if (push) begin
            pc_nxt = pc + ADDR_W'(2);
         end
         case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         pc    <= RESET_PC;
         count <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         count <= count_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (redirect_valid) begin
         // a pop in a redirect cycle is dropped along with everything else
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // storage is cleared on reset so out_pc/out_instr read zero until first push
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_pc[i]    <= '0;
            fifo_instr[i] <= '0;
         end
      end else if (push) begin
         fifo_pc[wr_ptr]    <= pc;
         fifo_instr[wr_ptr] <= imem_instr;
      end
   end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        halt_req = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        out_ready = 1'b0;
   logic [15:0] imem_addr;
   logic [15:0] imem_instr;
   logic        out_valid;
   logic [15:0] out_instr;
   logic [15:0] out_pc;
   logic        halted;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   localparam int M_IDLE  = 0;
   localparam int M_FETCH = 1;
   localparam int M_HALT  = 2;
   localparam int MDEPTH  = 2;

   int          mode;
   logic [15:0] m_pc;
   logic [15:0] q_pc[$];
   logic [15:0] q_ins[$];

   fetch_controller dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .halt_req       (halt_req),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return 16'h1000 + {1'b0, a[15:1]};
   endfunction

   assign imem_instr = mem_word(imem_addr);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors < 30)
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mode = M_IDLE;
      m_pc = 16'h0000;
      q_pc.delete();
      q_ins.delete();
   endtask

   always @(posedge clk) begin : model_step
      bit pop;
      bit push;
      int n;
      if (!reset) begin
         n    = q_pc.size();
         pop  = (n != 0) && out_ready;
         push = 1'b0;
         if (redirect_valid) begin
            q_pc.delete();
            q_ins.delete();
            m_pc = {redirect_pc[15:1], 1'b0};
         end else begin
            push = (mode == M_FETCH) && !halt_req && ((n < MDEPTH) || pop);
            if (pop) begin
               void'(q_pc.pop_front());
               void'(q_ins.pop_front());
            end
            if (push) begin
               q_pc.push_back(m_pc);
               q_ins.push_back(mem_word(m_pc));
               m_pc = m_pc + 16'd2;
            end
         end
         if (mode == M_IDLE && start)          mode = M_FETCH;
         else if (mode == M_FETCH && halt_req) mode = M_HALT;
         else if (mode == M_HALT && start)     mode = M_FETCH;
      end
   end

   always @(negedge clk) begin
      if (cmp_en && !reset) begin
         chk("imem_addr", imem_addr, m_pc);
         chk("out_valid", out_valid, q_pc.size() != 0);
         chk("halted", halted, mode == M_HALT);
         if (q_pc.size() != 0) begin
            chk("out_pc", out_pc, q_pc[0]);
            chk("out_instr", out_instr, q_ins[0]);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // reset pulse strictly between edges: asserted 2 after negedge, released before posedge
   task automatic mid_reset(input bit check_now);
      @(negedge clk);
      #2 reset = 1'b1;
      model_reset();
      #1;
      if (check_now) begin
         chk("rst_out_valid", out_valid, 1'b0);
         chk("rst_halted", halted, 1'b0);
         chk("rst_imem_addr", imem_addr, 16'h0000);
      end
      #1 reset = 1'b0;
   endtask

   initial begin
      model_reset();
      #12 reset = 1'b0;
      cmp_en = 1'b1;
      tick();
      chk("reset_imem_addr", imem_addr, 16'h0000);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_halted", halted, 1'b0);
      chk("reset_out_pc", out_pc, 16'h0000);
      chk("reset_out_instr", out_instr, 16'h0000);

      // streaming fetch
      out_ready = 1'b1;
      start = 1'b1;
      tick(); start = 1'b0;
      chk("t1_valid_n", out_valid, 1'b0);
      tick();
      chk("t1_valid_n1", out_valid, 1'b1);
      chk("t1_pc0", out_pc, 16'h0000);
      chk("t1_in0", out_instr, 16'h1000);
      tick();
      chk("t1_pc1", out_pc, 16'h0002);
      chk("t1_in1", out_instr, 16'h1001);
      tick();
      chk("t1_pc2", out_pc, 16'h0004);
      chk("t1_in2", out_instr, 16'h1002);

      // backpressure fills the FIFO
      mid_reset(1'b1);
      tick();
      out_ready = 1'b0;
      start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick();
      chk("t2_addr_full", imem_addr, 16'h0004);
      chk("t2_head", out_pc, 16'h0000);
      tick();
      chk("t2_addr_hold", imem_addr, 16'h0004);
      chk("t2_head_hold", out_pc, 16'h0000);
      out_ready = 1'b1;
      tick();
      chk("t2_pc1", out_pc, 16'h0002);
      tick();
      chk("t2_pc2", out_pc, 16'h0004);

      // redirect while full
      out_ready = 1'b0;
      tick(); tick();
      redirect_valid = 1'b1;
      redirect_pc = 16'h0031;
      tick(); redirect_valid = 1'b0;
      chk("t3_flush", out_valid, 1'b0);
      chk("t3_addr", imem_addr, 16'h0030);
      tick();
      chk("t3_valid", out_valid, 1'b1);
      chk("t3_pc", out_pc, 16'h0030);
      chk("t3_instr", out_instr, 16'h1018);

      // address wrap
      out_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 16'hFFFC;
      tick(); redirect_valid = 1'b0;
      tick(); chk("t4_pc0", out_pc, 16'hFFFC);
      tick(); chk("t4_pc1", out_pc, 16'hFFFE);
      tick(); chk("t4_pc2", out_pc, 16'h0000);
      tick(); chk("t4_pc3", out_pc, 16'h0002);

      // halt with full FIFO, drain, resume
      out_ready = 1'b0;
      tick(); tick();
      halt_req = 1'b1;
      tick(); halt_req = 1'b0;
      chk("t5_halted", halted, 1'b1);
      chk("t5_addr", imem_addr, 16'h0006);
      chk("t5_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      tick(); tick();
      chk("t5_drained", out_valid, 1'b0);
      chk("t5_addr_frozen", imem_addr, 16'h0006);
      start = 1'b1;
      tick(); start = 1'b0;
      chk("t5_resumed", halted, 1'b0);
      tick();
      chk("t5_resume_pc", out_pc, 16'h0006);

      // reset mid-run, then idle until start
      mid_reset(1'b1);
      repeat (3) tick();
      chk("t6_idle_valid", out_valid, 1'b0);
      chk("t6_idle_addr", imem_addr, 16'h0000);

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 599) == 0) begin
            start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
            mid_reset(1'b0);
         end else begin
            tick();
         end
         start          = ($urandom_range(0, 9) == 0);
         halt_req       = ($urandom_range(0, 11) == 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         out_ready      = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 3) == 0)
            redirect_pc = 16'hFFF0 | 16'($urandom_range(0, 15));
         else
            redirect_pc = 16'($urandom);
      end
      start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
